// File: rtl/thor2023_regwb_arbiter_pkg.sv
// Shared types and register-number constants for the integer register file
// write-back path.
package thor2023_regwb_arbiter_pkg;

  typedef logic [63:0] double_value_t;

  localparam int NWBSRC = 4;

  localparam logic [5:0] LCREG = 6'd55;
  localparam logic [5:0] SCREG = 6'd53;
  localparam logic [5:0] SPREG = 6'd63;

  typedef struct packed {
    logic [6:0]    tag;
    double_value_t data;
  } wb_entry_t;

endpackage

// File: rtl/thor2023_regwb_arbiter_if.sv
// Result-source and register-file write bundle of the write-back arbiter.
import thor2023_regwb_arbiter_pkg::*;

interface thor2023_regwb_arbiter_if;
  logic [NWBSRC-1:0]          src_valid;
  logic [NWBSRC-1:0]          src_ready;
  logic [NWBSRC-1:0][6:0]     src_tag;
  double_value_t [NWBSRC-1:0] src_data;
  logic [1:0]                 om;
  logic                       wr;
  logic [6:0]                 wa;
  double_value_t              i;
  logic [3:0]                 sp_wr;
  logic                       lc_wr;
  logic [NWBSRC-1:0]          wb_ack;

  modport master (
    output src_valid, src_tag, src_data, om,
    input  src_ready, wr, wa, i, sp_wr, lc_wr, wb_ack
  );

  modport slave (
    input  src_valid, src_tag, src_data, om,
    output src_ready, wr, wa, i, sp_wr, lc_wr, wb_ack
  );
endinterface

// File: rtl/thor2023_wb_fifo.sv
// Small per-source result FIFO; head is valid whenever empty is low.
module thor2023_wb_fifo
  import thor2023_regwb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t        mem [DEPTH];
  logic [PW-1:0]    wp, rp;
  logic [CW-1:0]    cnt;
  logic             push_ok, pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rp];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= nxt(wp);
      if (pop_ok)  rp <= nxt(rp);
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= din;
  end
endmodule

// File: rtl/thor2023_regwb_arbiter.sv
// Round-robin write-back arbiter: four buffered result sources share one
// register-file write port; SP and LC writes also raise dedicated strobes.
module thor2023_regwb_arbiter
  import thor2023_regwb_arbiter_pkg::*;
#(
  parameter int NSRC   = NWBSRC,
  parameter int FDEPTH = 2
) (
  input logic clk,
  input logic rst,
  thor2023_regwb_arbiter_if.slave wb
);
  localparam int SW = $clog2(NSRC);

  wb_entry_t         din  [NSRC];
  wb_entry_t         head [NSRC];
  logic [NSRC-1:0]   full, empty, pop;
  logic [SW-1:0]     rr, win, idx;
  logic              win_vld;
  wb_entry_t         sel;
  logic [5:0]        sel_addr;

  assign wb.src_ready = ~full;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign din[g] = '{tag: wb.src_tag[g], data: wb.src_data[g]};
    assign pop[g] = win_vld && (win == SW'(g));

    thor2023_wb_fifo #(.DEPTH(FDEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wb.src_valid[g]),
      .pop   (pop[g]),
      .din   (din[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .head  (head[g])
    );
  end

  // First non-empty FIFO at or after rr wins. Entries pushed this edge are
  // not yet visible in empty, so an entry always waits at least one cycle.
  always_comb begin
    win_vld = 1'b0;
    win     = rr;
    idx     = rr;
    for (int k = 0; k < NSRC; k++) begin
      idx = rr + SW'(k);
      if (!win_vld && !empty[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  assign sel      = head[win];
  assign sel_addr = sel.tag[5:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr        <= '0;
      wb.wr     <= 1'b0;
      wb.wa     <= '0;
      wb.i      <= '0;
      wb.sp_wr  <= '0;
      wb.lc_wr  <= 1'b0;
      wb.wb_ack <= '0;
    end else begin
      wb.wr     <= 1'b0;
      wb.sp_wr  <= '0;
      wb.lc_wr  <= 1'b0;
      wb.wb_ack <= '0;
      if (win_vld) begin
        rr        <= win + SW'(1);
        wb.wb_ack <= NSRC'(1) << win;
        // Tag 0 retires silently; SP goes only to the per-mode copy.
        if (sel_addr == SPREG) begin
          wb.sp_wr <= 4'b0001 << wb.om;
          wb.i     <= sel.data;
        end else if (sel_addr != '0) begin
          wb.wr    <= 1'b1;
          wb.wa    <= sel.tag;
          wb.i     <= sel.data;
          wb.lc_wr <= (sel_addr == LCREG);
        end
      end
    end
  end
endmodule

// File: tb/tb_thor2023_regwb_arbiter.sv
// Write-back arbiter bench: directed scenarios plus random traffic checked
// against a queue-based reference model.
module tb_thor2023_regwb_arbiter;
  import thor2023_regwb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  thor2023_regwb_arbiter_if wb ();

  thor2023_regwb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  wb_entry_t     q [4][$];
  int            rr_m;
  logic          e_wr, e_lc;
  logic [6:0]    e_wa;
  logic [63:0]   e_i;
  logic [3:0]    e_sp, e_ack, acc;

  // drive values for the next cycle
  logic [3:0]         v_in;
  logic [3:0][6:0]    t_in;
  logic [3:0][63:0]   d_in;
  logic [1:0]         om_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) q[k].delete();
    rr_m = 0;
    e_wr = 0; e_lc = 0; e_wa = '0; e_i = '0; e_sp = '0; e_ack = '0; acc = '0;
  endtask

  // What the next rising edge does: retire one entry, then accept pushes.
  task automatic model_step();
    logic [3:0] rdy;
    wb_entry_t  ent;
    int         a;
    for (int k = 0; k < 4; k++) rdy[k] = (q[k].size() < 2);
    e_wr = 0; e_sp = '0; e_lc = 0; e_ack = '0;
    for (int n = 0; n < 4; n++) begin
      int s;
      s = (rr_m + n) % 4;
      if (q[s].size() > 0) begin
        ent   = q[s].pop_front();
        rr_m  = (s + 1) % 4;
        e_ack = 4'(1 << s);
        a     = int'(ent.tag) % 64;
        if (a == 63) begin
          e_sp = 4'(1 << om_in);
          e_i  = ent.data;
        end else if (a != 0) begin
          e_wr = 1; e_wa = ent.tag; e_i = ent.data;
          e_lc = (a == 55);
        end
        break;
      end
    end
    for (int k = 0; k < 4; k++) begin
      acc[k] = v_in[k] && rdy[k];
      if (acc[k]) q[k].push_back('{tag: t_in[k], data: d_in[k]});
    end
  endtask

  // One cycle: check outputs of the last edge, drive, predict the next edge.
  task automatic cyc();
    logic [3:0] e_rdy;
    @(negedge clk);
    for (int k = 0; k < 4; k++) e_rdy[k] = (q[k].size() < 2);
    chk("wr",     64'(wb.wr),        64'(e_wr));
    chk("wa",     64'(wb.wa),        64'(e_wa));
    chk("i",      wb.i,              e_i);
    chk("sp_wr",  64'(wb.sp_wr),     64'(e_sp));
    chk("lc_wr",  64'(wb.lc_wr),     64'(e_lc));
    chk("wb_ack", 64'(wb.wb_ack),    64'(e_ack));
    chk("ready",  64'(wb.src_ready), 64'(e_rdy));
    wb.src_valid = v_in;
    wb.src_tag   = t_in;
    wb.src_data  = d_in;
    wb.om        = om_in;
    model_step();
  endtask

  task automatic idle(input int n);
    v_in = '0;
    for (int c = 0; c < n; c++) cyc();
  endtask

  task automatic push1(input int s, input logic [6:0] t, input logic [63:0] d);
    v_in = '0;
    v_in[s] = 1'b1;
    t_in[s] = t;
    d_in[s] = d;
    cyc();
    v_in = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    v_in = '0;
    wb.src_valid = '0;
    model_clear();
    #1;
    chk("rst_wr",     64'(wb.wr),        64'd0);
    chk("rst_wa",     64'(wb.wa),        64'd0);
    chk("rst_i",      wb.i,              64'd0);
    chk("rst_sp_wr",  64'(wb.sp_wr),     64'd0);
    chk("rst_lc_wr",  64'(wb.lc_wr),     64'd0);
    chk("rst_wb_ack", 64'(wb.wb_ack),    64'd0);
    chk("rst_ready",  64'(wb.src_ready), 64'hf);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0] rt;
    int         got3;
    v_in = '0; t_in = '0; d_in = '0; om_in = '0;
    wb.src_valid = '0; wb.src_tag = '0; wb.src_data = '0; wb.om = '0;
    model_clear();
    do_reset();

    // single write
    push1(0, 7'd5, 64'h1234);
    idle(2);
    chk("single_wr",  64'(wb.wr),     64'd1);
    chk("single_wa",  64'(wb.wa),     64'd5);
    chk("single_i",   wb.i,           64'h1234);
    chk("single_ack", 64'(wb.wb_ack), 64'b0001);
    idle(1);
    chk("single_pulse", 64'(wb.wr), 64'd0);

    // all four sources together
    v_in = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      t_in[k] = 7'(k + 1);
      d_in[k] = 64'(100 + k);
    end
    cyc();
    idle(6);

    // SP redirection with om=2, then LC
    om_in = 2'd2;
    push1(2, 7'd63, 64'hAA);
    idle(2);
    chk("sp_sp_wr", 64'(wb.sp_wr), 64'b0100);
    chk("sp_wr",    64'(wb.wr),    64'd0);
    chk("sp_i",     wb.i,          64'hAA);
    push1(1, 7'd55, 64'd7);
    idle(2);
    chk("lc_lc_wr", 64'(wb.lc_wr), 64'd1);
    chk("lc_wr",    64'(wb.wr),    64'd1);
    chk("lc_wa",    64'(wb.wa),    64'd55);

    // tag 0 discard
    push1(3, 7'd0, 64'd99);
    idle(2);
    chk("t0_ack", 64'(wb.wb_ack), 64'b1000);
    chk("t0_wr",  64'(wb.wr),     64'd0);
    chk("t0_sp",  64'(wb.sp_wr),  64'd0);
    chk("t0_lc",  64'(wb.lc_wr),  64'd0);
    idle(2);

    // backpressure on source 3 while the others keep their FIFOs busy
    v_in = 4'b1111;
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 4; k++) begin
        t_in[k] = 7'(8 + 4 * n + k);
        d_in[k] = 64'(1000 + 16 * n + k);
      end
      cyc();
    end
    t_in[3] = 7'd30;
    d_in[3] = 64'hB3;
    got3 = 0;
    for (int c = 0; c < 20 && got3 == 0; c++) begin
      for (int k = 0; k < 3; k++) begin
        t_in[k] = 7'(40 + k);
        d_in[k] = 64'(2000 + 4 * c + k);
      end
      cyc();
      if (acc[3]) got3 = 1;
    end
    chk("bp_third_accept", 64'(got3), 64'd1);
    idle(10);

    // reset with entries queued
    v_in = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      t_in[k] = 7'(20 + k);
      d_in[k] = 64'(3000 + k);
    end
    cyc();
    cyc();
    chk("pre_rst_queued", 64'(q[0].size() + q[1].size() + q[2].size() + q[3].size() >= 5), 64'd1);
    do_reset();
    idle(4);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      om_in = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) begin
        v_in[k] = ($urandom_range(0, 99) < 45);
        case ($urandom_range(0, 5))
          0:       rt = 7'd0;
          1:       rt = 7'd53;
          2:       rt = 7'd55;
          3:       rt = 7'd63;
          default: rt = 7'($urandom_range(0, 127));
        endcase
        t_in[k] = rt;
        d_in[k] = {$urandom, $urandom};
      end
      cyc();
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
